// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing decoder: rebuilds active-area pixel coordinates from hSync/vSync,
// checks line/frame lengths, tracks timing lock and keeps saturating error counters.
module vga_sync_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_LEN   = 640,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_LEN   = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        pix_en,
    input  logic        hSync,
    input  logic        vSync,
    input  logic        bright,
    input  logic [11:0] rgb,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        pix_valid,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic [7:0]  h_err_cnt,
    output logic [7:0]  v_err_cnt,
    output logic [7:0]  de_err_cnt
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [9:0] CNT_MAX   = 10'd1023;
    localparam logic [9:0] CNT_PRE   = 10'd1022;
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_BEG = 10'(H_ACT_START);
    localparam logic [9:0] H_ACT_END = 10'(H_ACT_START + H_ACT_LEN);
    localparam logic [9:0] V_ACT_BEG = 10'(V_ACT_START);
    localparam logic [9:0] V_ACT_END = 10'(V_ACT_START + V_ACT_LEN);
    localparam logic [3:0] LOCK_GOAL = 4'(LOCK_FRAMES);

    function automatic logic [7:0] satInc8(input logic [7:0] v, input logic inc);
        if (inc && (v != 8'hFF)) begin
            return v + 8'd1;
        end else begin
            return v;
        end
    endfunction

    logic       hSyncPrev_r, vSyncPrev_r;
    logic [9:0] hCount_r, vCount_r;
    state_t     state_r;
    logic [3:0] goodCnt_r;
    logic       frameErr_r;

    logic       hFall_s, vFall_s, hTimeout_s, vTimeout_s, hErr_s, vErr_s;
    logic [9:0] hCountNext_s, vCountNext_s;
    logic       active_s, pixValidNext_s, deErr_s, frameStartNext_s;
    state_t     stateNext_s;
    logic [3:0] goodNext_s;
    logic       frameErrNext_s;

    // Edge detection, position counters and line/frame length checks on the incoming sample
    always_comb begin
        hFall_s = pix_en & hSyncPrev_r & ~hSync;
        vFall_s = pix_en & vSyncPrev_r & ~vSync;

        if (!pix_en) begin
            hCountNext_s = hCount_r;
        end else if (hFall_s) begin
            hCountNext_s = 10'd0;
        end else if (hCount_r == CNT_MAX) begin
            hCountNext_s = hCount_r;
        end else begin
            hCountNext_s = hCount_r + 10'd1;
        end

        if (vFall_s) begin
            vCountNext_s = 10'd0;
        end else if (hFall_s && (vCount_r != CNT_MAX)) begin
            vCountNext_s = vCount_r + 10'd1;
        end else begin
            vCountNext_s = vCount_r;
        end

        // Timeouts fire once, on the step that lands the counter on its ceiling
        hTimeout_s = pix_en & ~hFall_s & (hCount_r == CNT_PRE);
        vTimeout_s = hFall_s & ~vFall_s & (vCount_r == CNT_PRE);

        if (state_r != SEARCH) begin
            hErr_s = (hFall_s & (hCount_r != H_LAST)) | hTimeout_s;
            vErr_s = (vFall_s & (vCount_r != V_LAST)) | vTimeout_s;
        end else begin
            hErr_s = 1'b0;
            vErr_s = 1'b0;
        end
    end

    // Lock state machine: next state, good-frame counter and per-frame error flag
    always_comb begin
        stateNext_s    = state_r;
        goodNext_s     = goodCnt_r;
        frameErrNext_s = frameErr_r | hErr_s | vErr_s;
        case (state_r)
            SEARCH: begin
                if (vFall_s) begin
                    stateNext_s    = ACQUIRE;
                    goodNext_s     = 4'd0;
                    frameErrNext_s = 1'b0;
                end else begin
                    stateNext_s = SEARCH;
                end
            end
            ACQUIRE: begin
                if (hTimeout_s || vTimeout_s) begin
                    stateNext_s = SEARCH;
                    goodNext_s  = 4'd0;
                end else if (vFall_s) begin
                    frameErrNext_s = 1'b0;
                    if (frameErr_r || hErr_s || vErr_s) begin
                        goodNext_s = 4'd0;
                    end else if ((goodCnt_r + 4'd1) >= LOCK_GOAL) begin
                        stateNext_s = LOCKED;
                        goodNext_s  = 4'd0;
                    end else begin
                        goodNext_s = goodCnt_r + 4'd1;
                    end
                end else begin
                    stateNext_s = ACQUIRE;
                end
            end
            LOCKED: begin
                if (hErr_s || vErr_s) begin
                    stateNext_s = SEARCH;
                    goodNext_s  = 4'd0;
                end else begin
                    stateNext_s = LOCKED;
                end
            end
            default: begin
                stateNext_s = SEARCH;
                goodNext_s  = 4'd0;
            end
        endcase
    end

    // Active-window decode and output strobes for the sample being taken
    always_comb begin
        active_s = (hCountNext_s >= H_ACT_BEG) && (hCountNext_s < H_ACT_END) &&
                   (vCountNext_s >= V_ACT_BEG) && (vCountNext_s < V_ACT_END);
        if (state_r == LOCKED) begin
            pixValidNext_s = pix_en & active_s & bright;
            deErr_s        = pix_en & (bright != active_s);
        end else begin
            pixValidNext_s = 1'b0;
            deErr_s        = 1'b0;
        end
        // A frame-length error on this edge drops lock, so it is not announced as a frame
        frameStartNext_s = vFall_s & (state_r == LOCKED) & (stateNext_s == LOCKED);
    end

    // State, counters and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hSyncPrev_r <= 1'b1;
            vSyncPrev_r <= 1'b1;
            hCount_r    <= 10'd0;
            vCount_r    <= 10'd0;
            state_r     <= SEARCH;
            goodCnt_r   <= 4'd0;
            frameErr_r  <= 1'b0;
            x           <= 10'd0;
            y           <= 10'd0;
            pix_valid   <= 1'b0;
            pix_rgb     <= 12'd0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            h_err_cnt   <= 8'd0;
            v_err_cnt   <= 8'd0;
            de_err_cnt  <= 8'd0;
        end else begin
            if (pix_en) begin
                hSyncPrev_r <= hSync;
                vSyncPrev_r <= vSync;
            end
            hCount_r    <= hCountNext_s;
            vCount_r    <= vCountNext_s;
            state_r     <= stateNext_s;
            goodCnt_r   <= goodNext_s;
            frameErr_r  <= frameErrNext_s;
            pix_valid   <= pixValidNext_s;
            frame_start <= frameStartNext_s;
            locked      <= (stateNext_s == LOCKED);
            if (pixValidNext_s) begin
                x       <= hCountNext_s - H_ACT_BEG;
                y       <= vCountNext_s - V_ACT_BEG;
                pix_rgb <= rgb;
            end
            h_err_cnt  <= satInc8(h_err_cnt, hErr_s);
            v_err_cnt  <= satInc8(v_err_cnt, vErr_s);
            de_err_cnt <= satInc8(de_err_cnt, deErr_s);
        end
    end

endmodule
